uart_packet_scheduler: RTL and testbench
========================================

Name: uart_packet_scheduler

Overview:
Multi-source packet framer and arbiter in front of the single uart_tx instance in the secure sensor top. Up to N_SRC producers each offer one encrypted reading, a cipher byte plus a checksum byte. The block grants them round-robin, captures the granted pair and serialises a 5-byte frame through the UART start/busy handshake. It replaces ad-hoc single-byte send FSMs and adds framing, source ID, sequence numbering and a frame-check byte.

Parameters:
N_SRC, 2, number of requesters (1..16)
SOF_BYTE, 8'hA5, start-of-frame byte
ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after a tx_start pulse

Ports:
clk  input  1  system clock
rst  input  1  reset: asynchronous, active-high
enable  input  1  when low, no new grants are made; an in-flight frame still completes
src_valid  input  N_SRC  per-source request; held high until the matching src_ack
src_cipher  input  8*N_SRC  cipher byte of source i at bits [8i+7:8i]
src_check  input  8*N_SRC  checksum byte of source i at bits [8i+7:8i]
src_ack  output  N_SRC  one-hot, one-cycle pulse: the request was captured
tx_start  output  1  one-cycle start pulse to uart_tx
tx_data  output  8  byte for uart_tx; stable from the tx_start cycle until the next ISSUE
tx_busy  input  1  uart_tx busy flag
pkt_active  output  1  high from grant until the frame completes
pkt_done  output  1  one-cycle pulse after the last byte has finished
seq_num  output  4  sequence number of the next frame
ack_err  output  1  sticky flag: an ACK_TIMEOUT expired; cleared only by reset

Behaviour:
- Reset (asynchronous): state=IDLE; rr_ptr=0.
- Reset values: all outputs 0, including seq_num.
- Reset mid-frame aborts the frame immediately. tx_start is low from the reset assertion. No pkt_done is produced.
- Frame byte order:
  - B0 = SOF_BYTE
  - B1 = {src_id[3:0], seq_num[3:0]}
  - B2 = captured cipher
  - B3 = captured checksum
  - B4 = B0^B1^B2^B3
- seq_num is sampled at grant.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE: when enable=1 and any src_valid:
  - Pick the first valid source searching from rr_ptr upward, with wrap.
  - Capture that source's cipher/check and its id.
  - Pulse src_ack[id] in the next cycle (registered).
  - Set rr_ptr = id+1 (wrap to 0 past N_SRC-1), byte_idx=0, pkt_active=1.
  - Go to ISSUE.
- IDLE with enable=0: stay in IDLE; src_ack stays 0.
- ISSUE: while tx_busy=1, wait (the UART may be in use elsewhere). When tx_busy=0: tx_data<=byte[byte_idx], tx_start<=1 for exactly one cycle, clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1 → go to WAIT_LO.
  - Otherwise increment the counter.
  - When the counter reaches ACK_TIMEOUT-1 with busy still low: set ack_err, treat the byte as sent, take the WAIT_LO exit path.
- WAIT_LO: when tx_busy=0:
  - If byte_idx<4: byte_idx++, go to ISSUE.
  - If byte_idx==4: pulse pkt_done, pkt_active<=0, seq_num++ (15 wraps to 0), go to IDLE.
- Latency:
  - src_valid seen at edge E → src_ack high after E.
  - If tx_busy=0, tx_start high after E+1.
  - Minimum frame length = 5 × (uart frame time + 2) cycles.
- Back-to-back requests: the earliest new grant is the cycle after returning to IDLE. The requester has dropped valid by then, since it is required to drop it one cycle after ack. The scheduler never samples src_valid outside IDLE.
- Simultaneous requests: strictly round-robin. A source granted last has lowest priority next.
- src_valid dropped before ack: no capture and no frame. Deasserting valid without ack is legal.
- enable falling mid-frame: the frame finishes normally, then the block stays in IDLE.
- Data inputs of non-granted sources are don't-care. The captured copy is immune to input changes after the grant.
- src_ack and tx_start never assert in the same cycle.

Test Plan:
- Single source 0 (cipher=0x3C, check=0x5A, seq=0), UART model with busy rising 1 cycle after start and lasting 10 cycles → bytes A5,00,3C,5A,C3. One src_ack[0] pulse, one pkt_done, seq_num=1.
- Sources 0 and 1 valid together, held for 3 frames → grant order 0,1,0. B1 = 0x00, 0x11, 0x02. src_ack one-hot each time.
- tx_busy held high for 50 cycles at grant → ISSUE waits, tx_start is issued only after busy falls. No byte is lost. ack_err=0.
- UART model never raises busy → each byte advances after ACK_TIMEOUT. ack_err=1 and stays 1. Frame completes with pkt_done.
- 17 consecutive frames from source 1 → seq_num wraps 15→0. Frame 17 carries B1=0x10.
- rst asserted during byte 2 → tx_start and all outputs 0 immediately, no pkt_done. After release, a new request starts at B0 with seq=0. enable=0 with valid high → no ack, no tx_start.

Source files
------------

// File: rtl/uart_packet_scheduler.sv
`default_nettype none
// ==========================================================================
// uart_packet_scheduler: round-robin arbiter/framer driving one uart_tx with
// 5-byte frames (SOF, id/seq, cipher, checksum, xor).   Revision: 1.0
// ==========================================================================
module uart_packet_scheduler #(
  parameter int         N_SRC       = 2,
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_cipher,
  input  logic [8*N_SRC-1:0] src_check,
  output logic [N_SRC-1:0]   src_ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               pkt_active,
  output logic               pkt_done,
  output logic [3:0]         seq_num,
  output logic               ack_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_rr_ptr, r_src_id, r_seq;
  logic [2:0]       r_byte_idx;
  logic [7:0]       r_cipher, r_check;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any, w_hi_found;
  logic [3:0]       w_low, w_hi, w_gnt;
  logic [7:0]       w_cipher, w_check, w_b1, w_byte;
  logic [N_SRC-1:0] w_ack_vec;
  logic             w_grant, w_issue, w_timeout, w_advance, w_finish;

  // Round-robin pick: lowest valid index at/above rr_ptr, else lowest overall.
  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_low      = '0;
    w_hi       = '0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (src_valid[j]) begin
        w_any = 1'b1;
        w_low = 4'(j);
        if (4'(j) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi       = 4'(j);
        end
      end
    end
    w_gnt     = w_hi_found ? w_hi : w_low;
    w_cipher  = '0;
    w_check   = '0;
    w_ack_vec = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (4'(j) == w_gnt) begin
        w_cipher     = src_cipher[8*j +: 8];
        w_check      = src_check[8*j +: 8];
        w_ack_vec[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_b1 = {r_src_id, r_seq};
    case (r_byte_idx)
      3'd0:    w_byte = SOF_BYTE;
      3'd1:    w_byte = w_b1;
      3'd2:    w_byte = r_cipher;
      3'd3:    w_byte = r_check;
      default: w_byte = SOF_BYTE ^ w_b1 ^ r_cipher ^ r_check;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_issue   = 1'b0;
    w_timeout = 1'b0;
    w_advance = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_any) begin
          w_grant = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          w_issue = 1'b1;
          w_next  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          w_next = WAIT_LO;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          // UART never acknowledged: flag it and treat the byte as sent.
          w_timeout = 1'b1;
          w_next    = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (r_byte_idx == 3'd4) begin
            w_finish = 1'b1;
            w_next   = IDLE;
          end else begin
            w_advance = 1'b1;
            w_next    = ISSUE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ack    <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      pkt_active <= 1'b0;
      pkt_done   <= 1'b0;
      seq_num    <= '0;
      ack_err    <= 1'b0;
      r_rr_ptr   <= '0;
      r_src_id   <= '0;
      r_seq      <= '0;
      r_byte_idx <= '0;
      r_cipher   <= '0;
      r_check    <= '0;
      r_cnt      <= '0;
    end else begin
      src_ack  <= w_grant ? w_ack_vec : '0;
      tx_start <= w_issue;
      pkt_done <= w_finish;
      if (w_grant) begin
        r_cipher   <= w_cipher;
        r_check    <= w_check;
        r_src_id   <= w_gnt;
        r_seq      <= seq_num;
        r_byte_idx <= '0;
        pkt_active <= 1'b1;
        r_rr_ptr   <= (w_gnt == 4'(N_SRC - 1)) ? 4'd0 : w_gnt + 4'd1;
      end
      if (w_issue) begin
        tx_data <= w_byte;
        r_cnt   <= '0;
      end else if (r_state == WAIT_HI && !tx_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) ack_err <= 1'b1;
      if (w_advance) r_byte_idx <= r_byte_idx + 3'd1;
      if (w_finish) begin
        pkt_active <= 1'b0;
        seq_num    <= seq_num + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_scheduler.sv
`default_nettype none
// tb_uart_packet_scheduler: scoreboard bench with a uart_tx busy model and
// per-source requesters that hold valid until acknowledged.
module tb_uart_packet_scheduler;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst, enable, tx_start, tx_busy, pkt_active, pkt_done, ack_err;
  logic [N-1:0]   src_valid, src_ack;
  logic [8*N-1:0] src_cipher, src_check;
  logic [7:0]     tx_data;
  logic [3:0]     seq_num;

  int n_cmp = 0, n_bad = 0;
  logic [7:0]   exp_bytes[$];
  logic [N-1:0] exp_ack[$];
  logic [7:0]   e_byte;
  logic [N-1:0] e_ack;
  int req_cnt[N];
  int done_cnt = 0, start_cnt = 0, ack_cnt = 0;
  logic uart_on, force_busy;
  int busy_left;
  int base_d, base_s, base_a;

  uart_packet_scheduler #(.N_SRC(N), .SOF_BYTE(8'hA5), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .src_valid(src_valid),
    .src_cipher(src_cipher), .src_check(src_check), .src_ack(src_ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .pkt_active(pkt_active), .pkt_done(pkt_done), .seq_num(seq_num),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) src_valid[i] = (req_cnt[i] != 0);
  end

  // uart_tx model: busy rises the cycle after tx_start and lasts 10 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)                        busy_left <= 0;
    else if (tx_start && uart_on)   busy_left <= 10;
    else if (busy_left != 0)        busy_left <= busy_left - 1;
  end
  assign tx_busy = force_busy | (busy_left != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at time %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte or an ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        start_cnt++;
        if (exp_bytes.size() == 0) fail_now("unexpected_tx_start");
        else begin
          e_byte = exp_bytes.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e_byte});
        end
      end
      if (src_ack != '0) begin
        ack_cnt++;
        if (exp_ack.size() == 0) fail_now("unexpected_src_ack");
        else begin
          e_ack = exp_ack.pop_front();
          check("src_ack", 32'(src_ack), 32'(e_ack));
        end
        for (int i = 0; i < N; i++)
          if (src_ack[i] && req_cnt[i] > 0) req_cnt[i] = req_cnt[i] - 1;
      end
      if (src_ack != '0 && tx_start) fail_now("ack_and_start_together");
      if (pkt_done) done_cnt++;
    end
  end

  task automatic push_frame(input logic [3:0] id, input logic [3:0] seq,
                            input logic [7:0] c, input logic [7:0] k);
    logic [7:0] b1;
    b1 = {id, seq};
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(b1);
    exp_bytes.push_back(c);
    exp_bytes.push_back(k);
    exp_bytes.push_back(8'hA5 ^ b1 ^ c ^ k);
    exp_ack.push_back(N'(1) << id);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check("pkt_done_count", done_cnt, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) req_cnt[i] = 0;
    exp_bytes.delete();
    exp_ack.delete();
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_src_ack"}, 32'(src_ack), 0);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_pkt_active"}, 32'(pkt_active), 0);
    check({tag, "_pkt_done"}, 32'(pkt_done), 0);
    check({tag, "_seq_num"}, 32'(seq_num), 0);
    check({tag, "_ack_err"}, 32'(ack_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; uart_on = 1'b1; force_busy = 1'b0;
    src_cipher = '0; src_check = '0;
    for (int i = 0; i < N; i++) req_cnt[i] = 0;
    #3;
    check_all_zero("in_reset");
    do_reset();
    check_all_zero("after_reset");

    // Single frame from source 0, fully hand-computed bytes.
    src_cipher = 16'h003C; src_check = 16'h005A;
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h3C); exp_bytes.push_back(8'h5A);
    exp_bytes.push_back(8'hC3); exp_ack.push_back(2'b01);
    base_a = ack_cnt;
    req_cnt[0] = 1;
    wait_done(done_cnt + 1, 200);
    check("t1_seq_num", 32'(seq_num), 1);
    check("t1_ack_count", ack_cnt - base_a, 1);
    check("t1_ack_err", 32'(ack_err), 0);
    check("t1_bytes_left", exp_bytes.size(), 0);

    // Two simultaneous sources: round-robin 0,1,0.
    do_reset();
    src_cipher = 16'h3311; src_check = 16'h4422;
    push_frame(4'd0, 4'd0, 8'h11, 8'h22);
    push_frame(4'd1, 4'd1, 8'h33, 8'h44);
    push_frame(4'd0, 4'd2, 8'h11, 8'h22);
    req_cnt[0] = 2; req_cnt[1] = 1;
    wait_done(done_cnt + 3, 600);
    check("t2_seq_num", 32'(seq_num), 3);
    check("t2_acks_left", exp_ack.size(), 0);
    check("t2_bytes_left", exp_bytes.size(), 0);

    // UART busy elsewhere at grant: ISSUE must wait.
    do_reset();
    src_cipher = 16'h7700; src_check = 16'h8800;
    force_busy = 1'b1;
    push_frame(4'd1, 4'd0, 8'h77, 8'h88);
    base_s = start_cnt;
    req_cnt[1] = 1;
    tick(50);
    check("t3_no_start_while_busy", start_cnt - base_s, 0);
    check("t3_pkt_active", 32'(pkt_active), 1);
    force_busy = 1'b0;
    wait_done(done_cnt + 1, 200);
    check("t3_ack_err", 32'(ack_err), 0);
    check("t3_bytes_left", exp_bytes.size(), 0);

    // UART never raises busy: every byte times out, ack_err sticks.
    do_reset();
    uart_on = 1'b0;
    src_cipher = 16'h0001; src_check = 16'h0002;
    push_frame(4'd0, 4'd0, 8'h01, 8'h02);
    req_cnt[0] = 1;
    wait_done(done_cnt + 1, 300);
    check("t4_ack_err_set", 32'(ack_err), 1);
    check("t4_bytes_left", exp_bytes.size(), 0);
    uart_on = 1'b1;
    push_frame(4'd0, 4'd1, 8'h01, 8'h02);
    req_cnt[0] = 1;
    wait_done(done_cnt + 1, 200);
    check("t4_ack_err_sticky", 32'(ack_err), 1);

    // 17 frames from source 1: sequence number wraps.
    do_reset();
    src_cipher = 16'hC300; src_check = 16'h9600;
    for (int f = 0; f < 17; f++) push_frame(4'd1, 4'(f), 8'hC3, 8'h96);
    req_cnt[1] = 17;
    wait_done(done_cnt + 17, 17 * 120);
    check("t5_seq_num_wrapped", 32'(seq_num), 1);
    check("t5_bytes_left", exp_bytes.size(), 0);

    // Reset during byte 2 aborts the frame with no pkt_done.
    do_reset();
    src_cipher = 16'h003C; src_check = 16'h005A;
    push_frame(4'd0, 4'd0, 8'h3C, 8'h5A);
    base_s = start_cnt;
    req_cnt[0] = 1;
    for (int c = 0; c < 200 && start_cnt - base_s < 3; c++) tick(1);
    check("t6_bytes_before_reset", start_cnt - base_s, 3);
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async_reset");
    check("t6_bytes_unsent", exp_bytes.size(), 2);
    exp_bytes.delete(); exp_ack.delete();
    base_d = done_cnt;
    tick(3);
    rst = 1'b0;
    tick(20);
    check("t6_no_pkt_done", done_cnt - base_d, 0);
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h3C); exp_bytes.push_back(8'h5A);
    exp_bytes.push_back(8'hC3); exp_ack.push_back(2'b01);
    req_cnt[0] = 1;
    wait_done(done_cnt + 1, 200);
    check("t6_seq_after", 32'(seq_num), 1);

    // enable low: no grant, no tx activity.
    do_reset();
    enable = 1'b0;
    base_a = ack_cnt; base_s = start_cnt;
    req_cnt[1] = 1;
    tick(30);
    check("t7_no_ack", ack_cnt - base_a, 0);
    check("t7_no_start", start_cnt - base_s, 0);
    check("t7_pkt_active", 32'(pkt_active), 0);
    req_cnt[1] = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
